// File: rtl/adder_stim_chk_if.sv
// Operand/result bus between the stimulus/checker (master) and the adder under test (slave).
interface adder_stim_chk_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   c;

  modport master (output a, output b, input c);
  modport slave  (input a, input b, output c);
endinterface

// File: rtl/adder_stim_chk.sv
// BIST-style driver/checker for a registered adder: LFSR operands out, latency-matched compare of c.
// Optional first-mismatch capture ports are enabled by defining ADDER_CHK_FIRST_ERR_EN.
module adder_stim_chk #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned NUM_TXN = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  adder_stim_chk_if.master       bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [15:0]            err_count,
  output logic [15:0]            txn_count
`ifdef ADDER_CHK_FIRST_ERR_EN
  ,
  output logic [WIDTH:0]         first_err_exp,
  output logic [WIDTH:0]         first_err_got,
  output logic [15:0]            first_err_idx
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  localparam logic [15:0] LAST_DRIVE = 16'(NUM_TXN - 1);
  localparam logic [15:0] LAST_DRAIN = 16'(LATENCY - 1);

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               drv_q, drv_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [WIDTH:0]     exp_q [LATENCY];
  logic [WIDTH:0]     exp_d [LATENCY];
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [15:0]        err_q, err_d;
  logic [15:0]        txn_q, txn_d;
  logic               accept;
  logic               emerge;
  logic               mismatch;
`ifdef ADDER_CHK_FIRST_ERR_EN
  logic [WIDTH:0]     ferr_exp_q, ferr_exp_d;
  logic [WIDTH:0]     ferr_got_q, ferr_got_d;
  logic [15:0]        ferr_idx_q, ferr_idx_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    a_d     = '0;
    b_d     = '0;
    drv_d   = 1'b0;
    err_d   = err_q;
    txn_d   = txn_q;
`ifdef ADDER_CHK_FIRST_ERR_EN
    ferr_exp_d = ferr_exp_q;
    ferr_got_d = ferr_got_q;
    ferr_idx_d = ferr_idx_q;
`endif

    // Outputs lag the state by one cycle, so DONE is only restartable once done is visible.
    accept = start && ((state_q == IDLE) || ((state_q == DONE) && done_q));

    // Push the pair currently on a/b; the tail lines up with the c it produced.
    vld_d    = '0;
    vld_d[0] = drv_q;
    exp_d[0] = {1'b0, a_q} + {1'b0, b_q};
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      exp_d[i] = exp_q[i-1];
    end

    emerge   = vld_q[LATENCY-1];
    mismatch = emerge && (bus.c != exp_q[LATENCY-1]);
    if (emerge) begin
      txn_d = txn_q + 16'd1;
    end
    if (mismatch && (err_q != '1)) begin
      err_d = err_q + 16'd1;
    end
`ifdef ADDER_CHK_FIRST_ERR_EN
    if (mismatch && (err_q == '0)) begin
      ferr_exp_d = exp_q[LATENCY-1];
      ferr_got_d = bus.c;
      ferr_idx_d = txn_q + 16'd1;
    end
`endif

    unique case (state_q)
      DRIVE: begin
        drv_d  = 1'b1;
        a_d    = lfsr_q[WIDTH-1:0];
        b_d    = lfsr_q[15 -: WIDTH];
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == LAST_DRIVE) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == LAST_DRAIN) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d = DRIVE;
      cnt_d   = '0;
      lfsr_d  = SEED;
      err_d   = '0;
      txn_d   = '0;
`ifdef ADDER_CHK_FIRST_ERR_EN
      ferr_exp_d = '0;
      ferr_got_d = '0;
      ferr_idx_d = '0;
`endif
    end

    busy_d = (state_q == DRIVE) || (state_q == DRAIN);
    done_d = (state_q == DONE) && !accept;
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      a_q     <= '0;
      b_q     <= '0;
      drv_q   <= 1'b0;
      vld_q   <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        exp_q[i] <= '0;
      end
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      txn_q   <= '0;
`ifdef ADDER_CHK_FIRST_ERR_EN
      ferr_exp_q <= '0;
      ferr_got_q <= '0;
      ferr_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      drv_q   <= drv_d;
      vld_q   <= vld_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
`ifdef ADDER_CHK_FIRST_ERR_EN
      ferr_exp_q <= ferr_exp_d;
      ferr_got_q <= ferr_got_d;
      ferr_idx_q <= ferr_idx_d;
`endif
    end
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign txn_count = txn_q;
`ifdef ADDER_CHK_FIRST_ERR_EN
  assign first_err_exp = ferr_exp_q;
  assign first_err_got = ferr_got_q;
  assign first_err_idx = ferr_idx_q;
`endif

endmodule

// File: tb/tb_adder_stim_chk.sv
// Directed bench: a LATENCY=1 checker (adder depth and c[0] fault selectable) and a LATENCY=3 checker.
module tb_adder_stim_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start1, start3;
  logic d1_busy, d1_done, d1_pass, d3_busy, d3_done, d3_pass;
  logic [15:0] d1_err, d1_txn, d3_err, d3_txn;
`ifdef ADDER_CHK_FIRST_ERR_EN
  logic [8:0]  d1_fexp, d1_fgot, d3_fexp, d3_fgot;
  logic [15:0] d1_fidx, d3_fidx;
`endif

  adder_stim_chk_if #(.WIDTH(8)) bus1 ();
  adder_stim_chk_if #(.WIDTH(8)) bus3 ();

  adder_stim_chk #(.WIDTH(8), .LATENCY(1), .NUM_TXN(16), .SEED(16'hACE1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .bus(bus1),
    .busy(d1_busy), .done(d1_done), .pass(d1_pass),
    .err_count(d1_err), .txn_count(d1_txn)
`ifdef ADDER_CHK_FIRST_ERR_EN
    , .first_err_exp(d1_fexp), .first_err_got(d1_fgot), .first_err_idx(d1_fidx)
`endif
  );

  adder_stim_chk #(.WIDTH(8), .LATENCY(3), .NUM_TXN(16), .SEED(16'hACE1)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .bus(bus3),
    .busy(d3_busy), .done(d3_done), .pass(d3_pass),
    .err_count(d3_err), .txn_count(d3_txn)
`ifdef ADDER_CHK_FIRST_ERR_EN
    , .first_err_exp(d3_fexp), .first_err_got(d3_fgot), .first_err_idx(d3_fidx)
`endif
  );

  // Reference adders: 1- or 3-stage for dut1 with optional stuck-at-0 on c[0], 3-stage for dut3.
  int unsigned lat1;
  logic        fault1;
  logic [8:0]  sr1 [3];
  logic [8:0]  sr3 [3];
  always @(posedge clk) begin
    sr1[0] <= {1'b0, bus1.a} + {1'b0, bus1.b};
    sr1[1] <= sr1[0];
    sr1[2] <= sr1[1];
    sr3[0] <= {1'b0, bus3.a} + {1'b0, bus3.b};
    sr3[1] <= sr3[0];
    sr3[2] <= sr3[1];
  end
  assign bus1.c = ((lat1 == 3) ? sr1[2] : sr1[0]) & (fault1 ? 9'h1FE : 9'h1FF);
  assign bus3.c = sr3[2];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse start at edge 0 and return the edge after which done first reads high (0 = timeout).
  task automatic run(input int unsigned which, output int unsigned done_edge,
                     output logic [7:0] first_a, output logic [7:0] first_b);
    if (which == 1) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    done_edge = 0;
    first_a   = '0;
    first_b   = '0;
    for (int unsigned e = 1; e <= 200; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        first_a = (which == 1) ? bus1.a : bus3.a;
        first_b = (which == 1) ? bus1.b : bus3.b;
      end
      if ((which == 1) ? d1_done : d3_done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  logic [7:0]  ma [1:16];
  logic [7:0]  mb [1:16];
  logic [8:0]  msum [1:16];
  int unsigned n_odd, first_odd;

  initial begin
    logic [15:0]  s;
    int unsigned  de;
    logic [7:0]   fa, fb;

    s = 16'hACE1;
    n_odd = 0;
    first_odd = 0;
    for (int unsigned k = 1; k <= 16; k++) begin
      ma[k]   = s[7:0];
      mb[k]   = s[15:8];
      msum[k] = {1'b0, ma[k]} + {1'b0, mb[k]};
      if (msum[k][0]) begin
        n_odd++;
        if (first_odd == 0) first_odd = k;
      end
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    end

    reset  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    lat1   = 1;
    fault1 = 1'b0;

    for (int unsigned i = 0; i < 3; i++) begin
      start1 = ~start1;
      start3 = ~start3;
      @(posedge clk); #1;
      check("rst_ab",   {bus1.a, bus1.b}, 32'h0);
      check("rst_flag", {d1_busy, d1_done, d1_pass, d3_busy}, 32'h0);
      check("rst_cnt",  {d1_err, d1_txn}, 32'h0);
    end
    start1 = 1'b0;
    start3 = 1'b0;
    reset  = 1'b1;
    @(posedge clk); #1;

    // Golden run with edge-by-edge timing checks.
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int unsigned e = 1; e <= 18; e++) begin
      @(posedge clk); #1;
      if (e <= 16) begin
        check("g_a", bus1.a, ma[e]);
        check("g_b", bus1.b, mb[e]);
      end
      if (e == 1) begin
        check("g_first_ab", {bus1.a, bus1.b}, 32'hE1AC);
        check("g_busy1", d1_busy, 1);
      end
      if (e == 2) check("g_second_ab", {bus1.a, bus1.b}, 32'h7056);
      if (e == 17) begin
        check("g_busy17", d1_busy, 1);
        check("g_done17", d1_done, 0);
        check("g_drain_a", bus1.a, 0);
        check("g_txn17", d1_txn, 15);
      end
      if (e == 18) begin
        check("g_busy18", d1_busy, 0);
        check("g_done18", d1_done, 1);
        check("g_txn", d1_txn, 16);
        check("g_err", d1_err, 0);
        check("g_pass", d1_pass, 1);
      end
    end

    // Stuck-at-0 on c[0]: every odd sum miscompares.
    fault1 = 1'b1;
    run(1, de, fa, fb);
    check("f_done_edge", de, 18);
    check("f_err", d1_err, n_odd);
    check("f_txn", d1_txn, 16);
    check("f_pass", d1_pass, 0);
`ifdef ADDER_CHK_FIRST_ERR_EN
    check("f_first_idx", d1_fidx, first_odd);
    check("f_first_exp", d1_fexp, msum[first_odd]);
    check("f_first_got", d1_fgot, msum[first_odd] & 9'h1FE);
`endif
    fault1 = 1'b0;

    // 3-stage adder against LATENCY=3 checker.
    run(3, de, fa, fb);
    check("l3_done_edge", de, 20);
    check("l3_err", d3_err, 0);
    check("l3_txn", d3_txn, 16);
    check("l3_pass", d3_pass, 1);

    // 3-stage adder against LATENCY=1 checker.
    lat1 = 3;
    run(1, de, fa, fb);
    check("l1m_done_edge", de, 18);
    check("l1m_err_nonzero", d1_err != 0, 1);
    check("l1m_pass", d1_pass, 0);
    lat1 = 1;

    // Reset in the middle of DRIVE.
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int unsigned e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
    end
    check("mr_txn_before", d1_txn, 5);
    reset = 1'b0;
    #1;
    check("mr_ab", {bus1.a, bus1.b}, 32'h0);
    check("mr_flags", {d1_busy, d1_done, d1_pass}, 32'h0);
    check("mr_cnt", {d1_err, d1_txn}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run(1, de, fa, fb);
    check("mr_first_ab", {fa, fb}, 32'hE1AC);
    check("mr_done_edge", de, 18);
    check("mr_txn", d1_txn, 16);
    check("mr_err", d1_err, 0);

    // start held high through a run and into DONE.
    start1 = 1'b1;
    @(posedge clk); #1;
    for (int unsigned e = 1; e <= 38; e++) begin
      @(posedge clk); #1;
      if (e == 10) check("h_busy_mid", d1_busy, 1);
      if (e == 18) begin
        check("h_done1", d1_done, 1);
        check("h_txn1", d1_txn, 16);
        check("h_err1", d1_err, 0);
      end
      if (e == 19) check("h_done_drop", d1_done, 0);
      if (e == 20) begin
        check("h_busy_restart", d1_busy, 1);
        check("h_restart_ab", {bus1.a, bus1.b}, 32'hE1AC);
      end
      if (e == 25) start1 = 1'b0;
      if (e == 36) check("h_done36", d1_done, 0);
      if (e == 37) begin
        check("h_done2", d1_done, 1);
        check("h_txn2", d1_txn, 16);
        check("h_err2", d1_err, 0);
        check("h_pass2", d1_pass, 1);
      end
      if (e == 38) check("h_done_hold", d1_done, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_stim_chk.md
Name: adder_stim_chk

Overview:
- Synthesizable initiator/checker for the registered adder interface (operands a, b out; sum c in).
- Generates a reproducible pseudo-random operand stream and drives it into the adder.
- Tracks each operand pair through a latency-matched expected-value pipeline, compares against returned c, and reports error and transaction counts.
- Sits opposite the adder as the BIST-style driver end of the same interface; usable in silicon bring-up and as a self-checking bench component.

Parameters:
- WIDTH, 8: operand width; legal range 1..16.
- LATENCY, 1: adder result latency in clock cycles; legal range 1..8.
- NUM_TXN, 16: operand pairs issued per run; legal range 1..65535.
- SEED, 16'hACE1: LFSR reset/reload value; must be non-zero.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: run request, sampled in IDLE or DONE.
- a, output, WIDTH: operand A to adder.
- b, output, WIDTH: operand B to adder.
- c, input, WIDTH+1: sum returned by adder.
- busy, output, 1: high in DRIVE and DRAIN.
- done, output, 1: high in DONE.
- pass, output, 1: high in DONE when err_count == 0.
- err_count, output, 16: mismatches in current/last run; saturates at 16'hFFFF.
- txn_count, output, 16: comparisons performed in current/last run.

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; a = b = 0; busy = done = pass = 0; err_count = txn_count = 0; LFSR = SEED; expected pipeline valid bits = 0.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, one shift per DRIVE cycle.
- Operand mapping: a = lfsr[WIDTH-1:0]; b = lfsr[15 -: WIDTH].
- FSM states: IDLE, DRIVE, DRAIN, DONE.
- IDLE: a = b = 0. start = 1 goes to DRIVE next cycle, with LFSR reloaded to SEED and both counters cleared.
- DRIVE: lasts exactly NUM_TXN cycles. a and b are registered outputs carrying pair k in DRIVE cycle k (k = 1..NUM_TXN). Pair 1 uses lfsr = SEED. After cycle NUM_TXN, goes to DRAIN.
- DRAIN: lasts exactly LATENCY cycles; a = b = 0. Then goes to DONE.
- DONE: done = 1; pass = (err_count == 0); counters hold. start = 1 restarts exactly as from IDLE (clears counters, reloads SEED, done drops next cycle). start = 0 stays in DONE.
- start while busy is ignored.
- Expected pipeline: per issued pair, push {valid = 1, exp = {1'b0,a} + {1'b0,b}} (WIDTH+1 bits, no truncation). Depth equals LATENCY, so the entry emerges on the cycle c for that pair is valid.
- Each emerging valid entry:
  - txn_count increments by 1.
  - If c != exp, err_count increments by 1 (saturating).
  - Cycles with no valid entry emerging perform no compare; c is ignored.
- Final compare occurs in the last DRAIN cycle, so txn_count == NUM_TXN on entry to DONE.
- Total run latency: start sampled at edge 0 gives done = 1 after edge NUM_TXN + LATENCY + 1.
- Reset mid-run: immediate return to reset values; in-flight pipeline entries are discarded, with no compare and no count.

Optional Feature:
- Macro ADDER_CHK_FIRST_ERR_EN.
- Defined: adds outputs first_err_exp (WIDTH+1), first_err_got (WIDTH+1), first_err_idx (16).
  - These capture exp, c, and txn index (1-based) of the first mismatch in a run.
  - They are 0 at reset and at run start, and hold until the next run or reset.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset hold: reset = 0 for 3 cycles with start toggling -> a = b = 0, busy = done = pass = 0, err_count = txn_count = 0 throughout.
- Golden run, WIDTH = 8, LATENCY = 1, NUM_TXN = 16, correct registered adder, start pulse at edge 0:
  - first a = 8'hE1, b = 8'hAC;
  - busy high edges 1..17;
  - done = 1 after edge 18;
  - txn_count = 16, err_count = 0, pass = 1.
- Faulty adder forcing c[0] = 0, same config -> err_count equals the count of odd sums among the 16 pairs (model-computed), pass = 0. With ADDER_CHK_FIRST_ERR_EN, first_err_idx = index of the first odd sum and first_err_got = first_err_exp & ~1.
- Latency match, LATENCY = 3 with a 3-stage adder -> err_count = 0, done after edge 20. Same DUT with LATENCY = 1 -> err_count > 0, pass = 0.
- Reset mid-DRIVE at edge 7, release, then start -> first pair again a = 8'hE1, b = 8'hAC; final txn_count = 16 (no stale compares).
- start held high through a run and into DONE -> mid-run start ignored; restart occurs on the first DONE cycle; second run results identical to the first.
